// File: rtl/prv_trap_sequencer_pkg.sv
// Machine-mode trap types shared by the trap sequencer and its prioritizer.
// Cause codes, FSM states, mstatus bit positions and CSR select encoding.
package prv_trap_sequencer_pkg;

    typedef enum logic [4:0] {
        EXC_MAL_INSN   = 5'd0,
        EXC_FAULT_INSN = 5'd1,
        EXC_ILLEGAL    = 5'd2,
        EXC_BREAK      = 5'd3,
        EXC_MAL_L      = 5'd4,
        EXC_FAULT_L    = 5'd5,
        EXC_MAL_S      = 5'd6,
        EXC_FAULT_S    = 5'd7,
        EXC_ENV_M      = 5'd11
    } exc_code_t;

    localparam logic [4:0] INT_SOFT  = 5'd3;
    localparam logic [4:0] INT_TIMER = 5'd7;
    localparam logic [4:0] INT_EXT   = 5'd11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REDIRECT,
        S_WAIT
    } state_t;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    typedef enum logic [1:0] {
        SEL_MEPC    = 2'd0,
        SEL_MCAUSE  = 2'd1,
        SEL_MTVAL   = 2'd2,
        SEL_MSTATUS = 2'd3
    } csr_sel_t;

    // Vectored mode only offsets interrupt entries; exceptions use the base.
    function automatic logic [31:0] trap_target(
        input logic [31:0] mtvec,
        input logic        vec_en,
        input logic        is_int,
        input logic [4:0]  code
    );
        logic [31:0] base;
        base = {mtvec[31:2], 2'b00};
        if (vec_en && (mtvec[1:0] == 2'b01) && is_int)
            return base + {25'd0, code, 2'b00};
        return base;
    endfunction

endpackage

// File: rtl/prv_trap_prioritizer.sv
// Picks the winning trap cause at the commit point.
// Exceptions beat interrupts; interrupts need global MIE.
module prv_trap_prioritizer
    import prv_trap_sequencer_pkg::*;
(
    input  logic [8:0] exc,
    input  logic [2:0] irq,
    input  logic       mie,
    output logic       valid,
    output logic       is_int,
    output logic [4:0] code
);

    logic [8:0] exc_oh;
    logic [2:0] irq_ord;
    logic [2:0] irq_oh;

    // exc bit order already matches priority, lowest index first
    assign exc_oh  = exc & (~exc + 9'd1);
    // irq is {ext, timer, soft}; reorder to {timer, soft, ext}
    assign irq_ord = {irq[1], irq[0], irq[2]};
    assign irq_oh  = irq_ord & (~irq_ord + 3'd1);

    // Decode the single surviving request into a cause code
    always_comb begin
        valid  = 1'b0;
        is_int = 1'b0;
        code   = 5'd0;
        if (|exc) begin
            valid = 1'b1;
            unique case (1'b1)
                exc_oh[0]: code = EXC_BREAK;
                exc_oh[1]: code = EXC_FAULT_INSN;
                exc_oh[2]: code = EXC_MAL_INSN;
                exc_oh[3]: code = EXC_ILLEGAL;
                exc_oh[4]: code = EXC_ENV_M;
                exc_oh[5]: code = EXC_MAL_L;
                exc_oh[6]: code = EXC_MAL_S;
                exc_oh[7]: code = EXC_FAULT_L;
                exc_oh[8]: code = EXC_FAULT_S;
                default:   code = 5'd0;
            endcase
        end else if (mie && (|irq)) begin
            valid  = 1'b1;
            is_int = 1'b1;
            unique case (1'b1)
                irq_oh[0]: code = INT_EXT;
                irq_oh[1]: code = INT_SOFT;
                irq_oh[2]: code = INT_TIMER;
                default:   code = 5'd0;
            endcase
        end
    end

endmodule

// File: rtl/prv_trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer with one-cycle PC redirect.
// Owns mepc/mcause/mtval and mstatus MIE/MPIE.
module prv_trap_sequencer
    import prv_trap_sequencer_pkg::*;
#(
    parameter logic VECTOR_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [8:0]  exc,
    input  logic        ret,
    input  logic        pipe_clear,
    input  logic [31:0] epc,
    input  logic [31:0] badaddr,
    input  logic        timer_int,
    input  logic        soft_int,
    input  logic        ext_int,
    input  logic [2:0]  mie_en,
    input  logic [31:0] mtvec,
    input  logic        csr_we,
    input  logic [1:0]  csr_sel,
    input  logic [31:0] csr_wdata,
    output logic [31:0] priv_pc,
    output logic        insert_pc,
    output logic        intr,
    output logic        busy,
    output logic [31:0] mepc,
    output logic [31:0] mcause,
    output logic [31:0] mtval,
    output logic        mstatus_mie,
    output logic        mstatus_mpie
);

    state_t      state;
    logic        p_valid;
    logic        p_int;
    logic [4:0]  p_code;
    logic [2:0]  irq;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;

    assign irq = {ext_int & mie_en[2],
                  timer_int & mie_en[1],
                  soft_int & mie_en[0]};

    prv_trap_prioritizer u_prio (
        .exc    (exc),
        .irq    (irq),
        .mie    (mstatus_mie),
        .valid  (p_valid),
        .is_int (p_int),
        .code   (p_code)
    );

    assign trap_pc = trap_target(mtvec, VECTOR_EN, p_int, p_code);

    // mtval source follows the cause class
    always_comb begin
        trap_tval = 32'd0;
        if (!p_int) begin
            unique case (p_code)
                EXC_BREAK:      trap_tval = epc;
                EXC_FAULT_INSN,
                EXC_MAL_INSN,
                EXC_MAL_L,
                EXC_MAL_S,
                EXC_FAULT_L,
                EXC_FAULT_S:    trap_tval = badaddr;
                default:        trap_tval = 32'd0;
            endcase
        end
    end

    // Sequencer FSM plus CSR state; events win over software writes
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= S_IDLE;
            mepc         <= 32'd0;
            mcause       <= 32'd0;
            mtval        <= 32'd0;
            priv_pc      <= 32'd0;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            insert_pc    <= 1'b0;
            intr         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            insert_pc <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (pipe_clear && p_valid) begin
                        mepc         <= {epc[31:2], 2'b00};
                        mcause       <= {p_int, 26'd0, p_code};
                        mtval        <= trap_tval;
                        mstatus_mpie <= mstatus_mie;
                        mstatus_mie  <= 1'b0;
                        priv_pc      <= trap_pc;
                        intr         <= p_int;
                        insert_pc    <= 1'b1;
                        busy         <= 1'b1;
                        state        <= S_REDIRECT;
                    end else if (pipe_clear && ret) begin
                        mstatus_mie  <= mstatus_mpie;
                        mstatus_mpie <= 1'b1;
                        priv_pc      <= mepc;
                        intr         <= 1'b0;
                        insert_pc    <= 1'b1;
                        busy         <= 1'b1;
                        state        <= S_REDIRECT;
                    end else if (csr_we) begin
                        unique case (csr_sel_t'(csr_sel))
                            SEL_MEPC:   mepc   <= {csr_wdata[31:2], 2'b00};
                            SEL_MCAUSE: mcause <= csr_wdata;
                            SEL_MTVAL:  mtval  <= csr_wdata;
                            SEL_MSTATUS: begin
                                mstatus_mie  <= csr_wdata[MSTATUS_MIE];
                                mstatus_mpie <= csr_wdata[MSTATUS_MPIE];
                            end
                        endcase
                    end
                end
                S_REDIRECT: state <= S_WAIT;
                S_WAIT: begin
                    if (!pipe_clear) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Self-checking bench for prv_trap_sequencer.
// Table vectors, hand sequences and random stimulus against a cause-rule model.
module tb_prv_trap_sequencer;

    localparam logic VEC = 1'b1;

    logic        CLK;
    logic        nRST;
    logic [8:0]  exc;
    logic        ret;
    logic        pipe_clear;
    logic [31:0] epc;
    logic [31:0] badaddr;
    logic        timer_int;
    logic        soft_int;
    logic        ext_int;
    logic [2:0]  mie_en;
    logic [31:0] mtvec;
    logic        csr_we;
    logic [1:0]  csr_sel;
    logic [31:0] csr_wdata;
    logic [31:0] priv_pc;
    logic        insert_pc;
    logic        intr;
    logic        busy;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic        mstatus_mie;
    logic        mstatus_mpie;

    prv_trap_sequencer #(.VECTOR_EN(VEC)) dut (
        .CLK(CLK), .nRST(nRST), .exc(exc), .ret(ret),
        .pipe_clear(pipe_clear), .epc(epc), .badaddr(badaddr),
        .timer_int(timer_int), .soft_int(soft_int), .ext_int(ext_int),
        .mie_en(mie_en), .mtvec(mtvec), .csr_we(csr_we),
        .csr_sel(csr_sel), .csr_wdata(csr_wdata), .priv_pc(priv_pc),
        .insert_pc(insert_pc), .intr(intr), .busy(busy), .mepc(mepc),
        .mcause(mcause), .mtval(mtval), .mstatus_mie(mstatus_mie),
        .mstatus_mpie(mstatus_mpie)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // exception bit i -> cause code, and mtval source (2=epc, 1=badaddr, 0=zero)
    int exc_code_tbl[9] = '{3, 1, 0, 2, 11, 4, 6, 5, 7};
    int exc_tval_tbl[9] = '{2, 1, 1, 0, 0, 1, 1, 1, 1};

    logic [31:0] m_mepc, m_mcause, m_mtval, m_pc;
    logic        m_mie, m_mpie, m_intr, m_ins, m_hold;

    typedef struct {
        logic [8:0]  exc;
        logic [2:0]  irq;
        logic [2:0]  en;
        logic        mie0;
        logic [31:0] mtvec;
        logic [31:0] epc;
        logic [31:0] bad;
        logic        take;
        logic [31:0] cause;
        logic [31:0] tval;
        logic [31:0] pc;
        logic        intr;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic mreset();
        m_mepc = 0; m_mcause = 0; m_mtval = 0; m_pc = 0;
        m_mie = 0; m_mpie = 0; m_intr = 0; m_ins = 0; m_hold = 0;
    endtask

    // Reference: next architectural state from the current inputs
    task automatic model_step();
        bit          took;
        bit          isint;
        int          code;
        logic [31:0] tv;
        logic [31:0] base;
        took = 0; isint = 0; code = 0; tv = 0;
        if (!m_ins && !m_hold) begin
            if (pipe_clear) begin
                for (int i = 0; i < 9; i++) begin
                    if (exc[i] && !took) begin
                        took = 1;
                        code = exc_code_tbl[i];
                        tv = exc_tval_tbl[i] == 2 ? epc :
                             exc_tval_tbl[i] == 1 ? badaddr : 32'd0;
                    end
                end
                if (!took && m_mie) begin
                    if (ext_int && mie_en[2]) begin
                        took = 1; isint = 1; code = 11;
                    end else if (soft_int && mie_en[0]) begin
                        took = 1; isint = 1; code = 3;
                    end else if (timer_int && mie_en[1]) begin
                        took = 1; isint = 1; code = 7;
                    end
                end
            end
            if (took) begin
                m_mepc = epc & ~32'h3;
                m_mcause = (isint ? 32'h8000_0000 : 32'h0) | 32'(code);
                m_mtval = tv;
                m_mpie = m_mie;
                m_mie = 0;
                base = mtvec & ~32'h3;
                if (VEC && mtvec[1:0] == 2'b01 && isint)
                    m_pc = base + 32'(4 * code);
                else
                    m_pc = base;
                m_intr = isint;
                m_ins = 1;
            end else if (pipe_clear && ret) begin
                m_mie = m_mpie;
                m_mpie = 1;
                m_pc = m_mepc;
                m_intr = 0;
                m_ins = 1;
            end else begin
                m_ins = 0;
                if (csr_we) begin
                    case (csr_sel)
                        2'd0: m_mepc = csr_wdata & ~32'h3;
                        2'd1: m_mcause = csr_wdata;
                        2'd2: m_mtval = csr_wdata;
                        default: begin
                            m_mie = csr_wdata[3];
                            m_mpie = csr_wdata[7];
                        end
                    endcase
                end
            end
            m_hold = 0;
        end else if (m_ins) begin
            m_ins = 0;
            m_hold = 1;
        end else if (!pipe_clear) begin
            m_hold = 0;
        end
    endtask

    task automatic check_all();
        chk("insert_pc", 32'(insert_pc), 32'(m_ins));
        chk("busy", 32'(busy), 32'(m_ins | m_hold));
        chk("priv_pc", priv_pc, m_pc);
        chk("intr", 32'(intr), 32'(m_intr));
        chk("mepc", mepc, m_mepc);
        chk("mcause", mcause, m_mcause);
        chk("mtval", mtval, m_mtval);
        chk("mie", 32'(mstatus_mie), 32'(m_mie));
        chk("mpie", 32'(mstatus_mpie), 32'(m_mpie));
    endtask

    task automatic step();
        model_step();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic clear_in();
        exc = 0; ret = 0; pipe_clear = 0; epc = 0; badaddr = 0;
        timer_int = 0; soft_int = 0; ext_int = 0; mie_en = 0;
        mtvec = 0; csr_we = 0; csr_sel = 0; csr_wdata = 0;
    endtask

    task automatic go_idle();
        clear_in();
        step();
        step();
    endtask

    task automatic csr_wr(input logic [1:0] sel, input logic [31:0] d);
        csr_we = 1; csr_sel = sel; csr_wdata = d;
        step();
        csr_we = 0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        go_idle();
        csr_wr(2'd3, {24'd0, 4'd0, v.mie0, 3'd0});
        exc = v.exc;
        {ext_int, timer_int, soft_int} = v.irq;
        mie_en = v.en; mtvec = v.mtvec; epc = v.epc; badaddr = v.bad;
        pipe_clear = 1;
        step();
        if (v.take) begin
            chk($sformatf("v%0d.insert", idx), 32'(insert_pc), 32'd1);
            chk($sformatf("v%0d.pc", idx), priv_pc, v.pc);
            chk($sformatf("v%0d.intr", idx), 32'(intr), 32'(v.intr));
            chk($sformatf("v%0d.cause", idx), mcause, v.cause);
            chk($sformatf("v%0d.tval", idx), mtval, v.tval);
            chk($sformatf("v%0d.mepc", idx), mepc, {v.epc[31:2], 2'b00});
            chk($sformatf("v%0d.mie", idx), 32'(mstatus_mie), 32'd0);
            chk($sformatf("v%0d.mpie", idx), 32'(mstatus_mpie), 32'(v.mie0));
        end else begin
            chk($sformatf("v%0d.noins", idx), 32'(insert_pc), 32'd0);
            chk($sformatf("v%0d.idle", idx), 32'(busy), 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("v%0d.single", idx), 32'(insert_pc), 32'd0);
        end
    endtask

    initial begin
        vt[0]  = '{9'h008, 3'b000, 3'b000, 1'b1, 32'h8000_0000, 32'h100,
                   32'h0, 1'b1, 32'h2, 32'h0, 32'h8000_0000, 1'b0};
        vt[1]  = '{9'h000, 3'b010, 3'b010, 1'b1, 32'h8000_0001, 32'h200,
                   32'h0, 1'b1, 32'h8000_0007, 32'h0, 32'h8000_001C, 1'b1};
        vt[2]  = '{9'h120, 3'b000, 3'b000, 1'b1, 32'h4000, 32'h204,
                   32'h2003, 1'b1, 32'h4, 32'h2003, 32'h4000, 1'b0};
        vt[3]  = '{9'h001, 3'b000, 3'b000, 1'b0, 32'h4000_0001, 32'h303,
                   32'hAAAA, 1'b1, 32'h3, 32'h303, 32'h4000_0000, 1'b0};
        vt[4]  = '{9'h000, 3'b111, 3'b111, 1'b1, 32'h1001, 32'h400,
                   32'h0, 1'b1, 32'h8000_000B, 32'h0, 32'h102C, 1'b1};
        vt[5]  = '{9'h000, 3'b011, 3'b111, 1'b1, 32'h1001, 32'h404,
                   32'h0, 1'b1, 32'h8000_0003, 32'h0, 32'h100C, 1'b1};
        vt[6]  = '{9'h010, 3'b010, 3'b010, 1'b1, 32'h2001, 32'h500,
                   32'h77, 1'b1, 32'hB, 32'h0, 32'h2000, 1'b0};
        vt[7]  = '{9'h006, 3'b000, 3'b000, 1'b1, 32'h3000, 32'h600,
                   32'h601, 1'b1, 32'h1, 32'h601, 32'h3000, 1'b0};
        vt[8]  = '{9'h000, 3'b111, 3'b111, 1'b0, 32'h1001, 32'h700,
                   32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0};
        vt[9]  = '{9'h080, 3'b000, 3'b000, 1'b1, 32'h5000, 32'h800,
                   32'h8888, 1'b1, 32'h5, 32'h8888, 32'h5000, 1'b0};
        vt[10] = '{9'h0C0, 3'b000, 3'b000, 1'b1, 32'h6000, 32'h804,
                   32'h9999, 1'b1, 32'h6, 32'h9999, 32'h6000, 1'b0};
        vt[11] = '{9'h030, 3'b000, 3'b000, 1'b1, 32'h7000, 32'h900,
                   32'h1234, 1'b1, 32'hB, 32'h0, 32'h7000, 1'b0};
        vt[12] = '{9'h000, 3'b111, 3'b000, 1'b1, 32'h1001, 32'hA00,
                   32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0};

        clear_in();
        mreset();
        nRST = 1;
        #1 nRST = 0;
        #2;
        chk("rst.insert", 32'(insert_pc), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.pc", priv_pc, 32'd0);
        chk("rst.intr", 32'(intr), 32'd0);
        chk("rst.mepc", mepc, 32'd0);
        chk("rst.mcause", mcause, 32'd0);
        chk("rst.mtval", mtval, 32'd0);
        chk("rst.mie", 32'(mstatus_mie), 32'd0);
        chk("rst.mpie", 32'(mstatus_mpie), 32'd0);
        repeat (2) @(posedge CLK);
        #3 nRST = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle.noins", 32'(insert_pc), 32'd0);
        end

        foreach (vt[i]) apply_vec(vt[i], i);

        // software mepc write, then MRET to it
        go_idle();
        csr_wr(2'd0, 32'h1237);
        chk("csr.mepc", mepc, 32'h1234);
        csr_wr(2'd3, 32'h80);
        ret = 1; pipe_clear = 1;
        step();
        chk("ret.insert", 32'(insert_pc), 32'd1);
        chk("ret.pc", priv_pc, 32'h1234);
        chk("ret.intr", 32'(intr), 32'd0);
        chk("ret.mie", 32'(mstatus_mie), 32'd1);
        chk("ret.mpie", 32'(mstatus_mpie), 32'd1);

        // exception and ret together: exception wins
        go_idle();
        exc = 9'h008; ret = 1; pipe_clear = 1; epc = 32'hC00;
        mtvec = 32'h9000;
        step();
        chk("excret.cause", mcause, 32'h2);
        chk("excret.mepc", mepc, 32'hC00);
        chk("excret.pc", priv_pc, 32'h9000);
        // write while the sequencer is busy is dropped
        exc = 0; ret = 0;
        csr_we = 1; csr_sel = 2'd2; csr_wdata = 32'hDEAD;
        step();
        step();
        chk("busywr.mtval", mtval, 32'h0);

        // event beats a coincident CSR write
        go_idle();
        exc = 9'h001; epc = 32'hD06; pipe_clear = 1;
        csr_we = 1; csr_sel = 2'd1; csr_wdata = 32'h55;
        step();
        chk("bpwr.cause", mcause, 32'h3);
        chk("bpwr.tval", mtval, 32'hD06);

        // pending interrupt waits for MIE, then enters
        go_idle();
        csr_wr(2'd3, 32'h0);
        timer_int = 1; mie_en = 3'b010; pipe_clear = 1;
        mtvec = 32'h8000_0001; epc = 32'hE00;
        step();
        chk("pend.noins", 32'(insert_pc), 32'd0);
        csr_wr(2'd3, 32'h8);
        chk("pend.mie", 32'(mstatus_mie), 32'd1);
        chk("pend.noins2", 32'(insert_pc), 32'd0);
        step();
        chk("pend.insert", 32'(insert_pc), 32'd1);
        chk("pend.cause", mcause, 32'h8000_0007);
        chk("pend.pc", priv_pc, 32'h8000_001C);

        // asynchronous reset while in REDIRECT
        go_idle();
        csr_wr(2'd3, 32'h8);
        exc = 9'h020; badaddr = 32'h4321; epc = 32'hF00;
        mtvec = 32'hA000; pipe_clear = 1;
        step();
        chk("arst.pre", 32'(insert_pc), 32'd1);
        #2 nRST = 0;
        #1;
        chk("arst.insert", 32'(insert_pc), 32'd0);
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.mepc", mepc, 32'd0);
        chk("arst.mcause", mcause, 32'd0);
        chk("arst.mtval", mtval, 32'd0);
        chk("arst.pc", priv_pc, 32'd0);
        clear_in();
        mreset();
        #1 nRST = 1;
        step();
        step();

        // random traffic against the model
        for (int c = 0; c < 600; c++) begin
            exc = ($urandom_range(0, 4) == 0) ? 9'($urandom) : 9'h0;
            ret = ($urandom_range(0, 5) == 0);
            pipe_clear = ($urandom_range(0, 9) < 7);
            {ext_int, timer_int, soft_int} = 3'($urandom);
            mie_en = 3'($urandom);
            mtvec = ($urandom & ~32'h3) | 32'($urandom_range(0, 1));
            epc = $urandom;
            badaddr = $urandom;
            csr_we = ($urandom_range(0, 3) == 0);
            csr_sel = 2'($urandom);
            csr_wdata = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
